// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the SISC unified-memory arbiter.
package sisc_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Fetch/data winner selection with a bounded data burst so fetch cannot starve.
module mem_arb_sel
    import sisc_mem_pkg::*;
#(
    parameter int DATA_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic arb_en,
    output logic sel_valid,
    output logic sel_port
);

    localparam int BW = $clog2(DATA_BURST + 1);

    logic [BW-1:0] burst_cnt;
    logic          burst_full;

    assign burst_full = (burst_cnt == BW'(DATA_BURST));

    always_comb begin
        sel_valid = arb_en && (if_req || dm_req);
        sel_port  = (dm_req && !(if_req && burst_full)) ? PORT_DM : PORT_IF;
    end

    // Only data grants won against a waiting fetch count toward the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (arb_en) begin
            if (!if_req || sel_port == PORT_IF)
                burst_cnt <= '0;
            else if (!burst_full)
                burst_cnt <= burst_cnt + BW'(1);
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter: one transaction at a time, fixed read latency.
// Define MEM_ARB_PERF_EN to add saturating grant/conflict counters.
module mem_arb
    import sisc_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 1,
    parameter int DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       if_cnt,
    output logic [15:0]       dm_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int LW       = $clog2(MEM_LAT + 1);
    localparam int WAIT_CYC = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;

    arb_state_e        state, state_nxt;
    logic [LW-1:0]     lat_cnt, lat_nxt;
    logic              cur_port, port_nxt;
    logic              if_gnt_nxt, dm_gnt_nxt, if_rv_nxt, dm_rv_nxt;
    logic              mem_en_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt, rdata_nxt;
    logic              sel_valid, sel_port;
    logic              arb_en;

    assign arb_en = (state == IDLE);
    assign busy   = (state != IDLE);

    mem_arb_sel #(.DATA_BURST(DATA_BURST)) u_sel (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .dm_req    (dm_req),
        .arb_en    (arb_en),
        .sel_valid (sel_valid),
        .sel_port  (sel_port)
    );

    always_comb begin
        state_nxt  = state;
        lat_nxt    = lat_cnt;
        port_nxt   = cur_port;
        if_gnt_nxt = 1'b0;
        dm_gnt_nxt = 1'b0;
        if_rv_nxt  = 1'b0;
        dm_rv_nxt  = 1'b0;
        mem_en_nxt = 1'b0;
        mem_we_nxt = 1'b0;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;
        rdata_nxt  = rdata;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_nxt  = ISSUE;
                    port_nxt   = sel_port;
                    mem_en_nxt = 1'b1;
                    if (sel_port == PORT_DM) begin
                        dm_gnt_nxt = 1'b1;
                        mem_we_nxt = dm_we;
                        addr_nxt   = dm_addr;
                        if (dm_we)
                            wdata_nxt = dm_wdata;
                    end else begin
                        if_gnt_nxt = 1'b1;
                        addr_nxt   = if_addr;
                    end
                end
            end
            ISSUE: begin
                // mem_we is still the registered store flag of this transaction
                if (mem_we) begin
                    state_nxt = IDLE;
                end else if (MEM_LAT == 1) begin
                    state_nxt = RESP;
                    rdata_nxt = mem_rdata;
                    if_rv_nxt = (cur_port == PORT_IF);
                    dm_rv_nxt = (cur_port == PORT_DM);
                end else begin
                    state_nxt = WAIT;
                    lat_nxt   = LW'(WAIT_CYC);
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = RESP;
                    rdata_nxt = mem_rdata;
                    if_rv_nxt = (cur_port == PORT_IF);
                    dm_rv_nxt = (cur_port == PORT_DM);
                end else begin
                    lat_nxt = lat_cnt - LW'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            cur_port  <= PORT_IF;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_nxt;
            cur_port  <= port_nxt;
            if_gnt    <= if_gnt_nxt;
            dm_gnt    <= dm_gnt_nxt;
            if_rvalid <= if_rv_nxt;
            dm_rvalid <= dm_rv_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            rdata     <= rdata_nxt;
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if_cnt       <= '0;
            dm_cnt       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (sel_valid && sel_port == PORT_IF && if_cnt != 16'hFFFF)
                if_cnt <= if_cnt + 16'd1;
            if (sel_valid && sel_port == PORT_DM && dm_cnt != 16'hFFFF)
                dm_cnt <= dm_cnt + 16'd1;
            if (arb_en && if_req && dm_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: instance 0 at MEM_LAT=1, instance 1 at MEM_LAT=3.
module tb_mem_arb;

    localparam int AW = 16;
    localparam int DW = 32;

    localparam int K_IF_GNT = 0;
    localparam int K_DM_GNT = 1;
    localparam int K_IF_RV  = 2;
    localparam int K_DM_RV  = 3;

    typedef struct {
        int            kind;
        int            cyc;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]         rst, if_req, dm_req, dm_we;
    logic [1:0][AW-1:0] if_addr, dm_addr, mem_addr;
    logic [1:0][DW-1:0] dm_wdata, mem_wdata, mem_rdata, rdata;
    logic [1:0]         if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
`ifdef MEM_ARB_PERF_EN
    logic [1:0][15:0]   if_cnt, dm_cnt, conflict_cnt;
`endif

    logic [DW-1:0] mem [2][256];

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    mem_arb #(.MEM_LAT(1), .DATA_BURST(4)) u0 (
        .clk(clk), .rst(rst[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]), .if_rvalid(if_rvalid[0]),
        .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
        .dm_gnt(dm_gnt[0]), .dm_rvalid(dm_rvalid[0]), .rdata(rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
`ifdef MEM_ARB_PERF_EN
        , .if_cnt(if_cnt[0]), .dm_cnt(dm_cnt[0]), .conflict_cnt(conflict_cnt[0])
`endif
    );

    mem_arb #(.MEM_LAT(3), .DATA_BURST(4)) u1 (
        .clk(clk), .rst(rst[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]), .if_rvalid(if_rvalid[1]),
        .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
        .dm_gnt(dm_gnt[1]), .dm_rvalid(dm_rvalid[1]), .rdata(rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
`ifdef MEM_ARB_PERF_EN
        , .if_cnt(if_cnt[1]), .dm_cnt(dm_cnt[1]), .conflict_cnt(conflict_cnt[1])
`endif
    );

    // Memory model: read data is driven only in cycle mem_en + (LAT-1), garbage otherwise.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        localparam int LAT = (g == 0) ? 1 : 3;
        int   age  = 0;
        logic live = 1'b0;
        logic rd_ok;
        always @(posedge clk) begin
            if (mem_en[g] && !mem_we[g]) begin
                age  <= 1;
                live <= 1'b1;
            end else if (live) begin
                age <= age + 1;
            end
        end
        assign rd_ok = (LAT == 1) ? (mem_en[g] && !mem_we[g]) : (live && age == LAT - 1);
        assign mem_rdata[g] = rd_ok ? mem[g][mem_addr[g][7:0]] : 32'hBAD0BAD0;
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push(input int d, input int kind, input int c, input logic [AW-1:0] a,
                        input logic we, input logic [DW-1:0] data);
        exp_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.we = we; e.data = data;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic observe(input int d, input int kind);
        exp_t e;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            chk($sformatf("dut%0d unexpected event kind", d), kind, 99);
            return;
        end
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        chk($sformatf("dut%0d event kind", d), kind, e.kind);
        chk($sformatf("dut%0d event cycle", d), cyc, e.cyc);
        if (kind == K_IF_GNT || kind == K_DM_GNT) begin
            chk($sformatf("dut%0d mem_en at gnt", d), mem_en[d], 1'b1);
            chk($sformatf("dut%0d mem_addr", d), mem_addr[d], e.addr);
            chk($sformatf("dut%0d mem_we", d), mem_we[d], e.we);
            if (e.we) chk($sformatf("dut%0d mem_wdata", d), mem_wdata[d], e.data);
        end else begin
            chk($sformatf("dut%0d rdata", d), rdata[d], e.data);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (if_gnt[d])    observe(d, K_IF_GNT);
            if (dm_gnt[d])    observe(d, K_DM_GNT);
            if (if_rvalid[d]) observe(d, K_IF_RV);
            if (dm_rvalid[d]) observe(d, K_DM_RV);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int d);
        chk($sformatf("dut%0d reset ctl", d),
            {busy[d], if_gnt[d], dm_gnt[d], if_rvalid[d], dm_rvalid[d], mem_en[d], mem_we[d]}, '0);
        chk($sformatf("dut%0d reset rdata", d), rdata[d], '0);
        chk($sformatf("dut%0d reset mem_addr", d), mem_addr[d], '0);
        chk($sformatf("dut%0d reset mem_wdata", d), mem_wdata[d], '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = '1; if_req = '0; dm_req = '0; dm_we = '0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) mem[d][i] = 32'h0;
        mem[0][8'h04] = 32'hDEADBEEF;
        mem[0][8'h08] = 32'h11112222;
        mem[0][8'h20] = 32'h00C0FFEE;
        mem[0][8'h40] = 32'h40404040;
        mem[1][8'h04] = 32'hDEADBEEF;
        mem[1][8'h50] = 32'h55555555;
        mem[1][8'h54] = 32'h54545454;

        tick(2);
        chk_reset(0);
        chk_reset(1);
        rst = '0;
        tick(1);

        // 1: fetch read, MEM_LAT=1
        t = cyc;
        if_req[0] = 1'b1; if_addr[0] = 16'h0004;
        push(0, K_IF_GNT, t + 1, 16'h0004, 1'b0, '0);
        push(0, K_IF_RV,  t + 2, '0, 1'b0, 32'hDEADBEEF);
        tick(1);
        if_req[0] = 1'b0;
        tick(1);
        chk("t1 busy in RESP", busy[0], 1'b1);
        chk("t1 mem_en off after ISSUE", mem_en[0], 1'b0);
        tick(1);
        chk("t1 busy low at T+3", busy[0], 1'b0);

        // 2: store, then a second store held from the grant cycle
        t = cyc;
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 16'h0010; dm_wdata[0] = 32'h12345678;
        push(0, K_DM_GNT, t + 1, 16'h0010, 1'b1, 32'h12345678);
        tick(1);
        dm_addr[0] = 16'h0018; dm_wdata[0] = 32'hCAFEF00D;
        push(0, K_DM_GNT, t + 3, 16'h0018, 1'b1, 32'hCAFEF00D);
        tick(2);
        dm_req[0] = 1'b0;
        tick(1);
        chk("t2 rdata held across stores", rdata[0], 32'hDEADBEEF);

        // 3: simultaneous fetch + load, data wins
        t = cyc;
        if_req[0] = 1'b1; if_addr[0] = 16'h0008;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 16'h0020;
        push(0, K_DM_GNT, t + 1, 16'h0020, 1'b0, '0);
        push(0, K_DM_RV,  t + 2, '0, 1'b0, 32'h00C0FFEE);
        push(0, K_IF_GNT, t + 4, 16'h0008, 1'b0, '0);
        push(0, K_IF_RV,  t + 5, '0, 1'b0, 32'h11112222);
        tick(1);
        dm_req[0] = 1'b0;
        tick(3);
        if_req[0] = 1'b0;
        tick(2);

        // 4: starvation guard, four data grants then fetch
        t = cyc;
        if_req[0] = 1'b1; if_addr[0] = 16'h0040;
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 16'h0030; dm_wdata[0] = 32'h100;
        for (int k = 0; k < 4; k++)
            push(0, K_DM_GNT, t + 1 + 2 * k, 16'h0030 + 16'(k), 1'b1, 32'h100 + k);
        push(0, K_IF_GNT, t + 9,  16'h0040, 1'b0, '0);
        push(0, K_IF_RV,  t + 10, '0, 1'b0, 32'h40404040);
        push(0, K_DM_GNT, t + 12, 16'h0034, 1'b1, 32'h104);
        tick(1);
        for (int k = 1; k <= 4; k++) begin
            dm_addr[0]  = 16'h0030 + 16'(k);
            dm_wdata[0] = 32'h100 + k;
            tick(2);
        end
        if_req[0] = 1'b0;
        tick(1);
        chk("t4 burst_cnt cleared", 32'(u0.u_sel.burst_cnt), 0);
        tick(2);
        dm_req[0] = 1'b0;
        tick(2);

        // 5: reset during a MEM_LAT=3 load
        t = cyc;
        dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 16'h0050;
        push(1, K_DM_GNT, t + 1, 16'h0050, 1'b0, '0);
        tick(1);
        dm_req[1] = 1'b0;
        tick(1);
        rst[1] = 1'b1;
        tick(1);
        chk_reset(1);
        rst[1] = 1'b0;
        t = cyc;
        dm_req[1] = 1'b1; dm_addr[1] = 16'h0054;
        push(1, K_DM_GNT, t + 1, 16'h0054, 1'b0, '0);
        push(1, K_DM_RV,  t + 4, '0, 1'b0, 32'h54545454);
        tick(1);
        dm_req[1] = 1'b0;
        tick(4);
        chk("t5 busy low after load", busy[1], 1'b0);

        // 6: fetch read, MEM_LAT=3
        t = cyc;
        if_req[1] = 1'b1; if_addr[1] = 16'h0004;
        push(1, K_IF_GNT, t + 1, 16'h0004, 1'b0, '0);
        push(1, K_IF_RV,  t + 4, '0, 1'b0, 32'hDEADBEEF);
        tick(1);
        if_req[1] = 1'b0;
        tick(1);
        chk("t6 busy in WAIT", busy[1], 1'b1);
        tick(3);
        chk("t6 busy low", busy[1], 1'b0);
`ifdef MEM_ARB_PERF_EN
        chk("perf dut1 if_cnt", if_cnt[1], 16'd1);
        chk("perf dut1 dm_cnt", dm_cnt[1], 16'd1);
        chk("perf dut0 if_cnt", if_cnt[0], 16'd3);
        chk("perf dut0 dm_cnt", dm_cnt[0], 16'd8);
        chk("perf dut0 conflict_cnt", conflict_cnt[0], 16'd6);
`endif

        tick(3);
        chk("dut0 scoreboard drained", sb0.size(), 0);
        chk("dut1 scoreboard drained", sb1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
